// File: rtl/mux16_rr_sched_pkg.sv
// mux_sched_pkg: shared widths and FSM state encoding for the 16-channel mux scheduler
package mux_sched_pkg;
  localparam int N_CH  = 16;
  localparam int SEL_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, GRANT = 2'd2} state_e;
endpackage

// File: rtl/mux16_rr_sched_if.sv
// mux16_rr_sched_if: request/grant bundle between requesters and the mux scheduler
// master drives en/req/mask and observes sel/gnt/valid/busy; slave is the scheduler side
interface mux16_rr_sched_if;
  import mux_sched_pkg::*;
  logic             en;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  mask;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  gnt;
  logic             valid;
  logic             busy;
  modport master (output en, req, mask, input sel, gnt, valid, busy);
  modport slave  (input en, req, mask, output sel, gnt, valid, busy);
endinterface

// File: rtl/mux16_rr_sched_rr_pick.sv
// rr_pick: rotated priority encoder, first set bit of r searching upward from ptr+1
// ports: r (effective requests), ptr (last granted index) -> idx (pick), any (r nonzero)
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  r,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  assign any = |r;
  // walk offsets from farthest to nearest so the nearest set bit after ptr wins
  always_comb begin
    idx = '0;
    for (int k = N_CH; k > 0; k--)
      if (r[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
  end
endmodule

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin owner of a shared 16:1 mux with settle cycle and hold limit
// ports: clk, rst_n (async active-low), bus (slave: en/req/mask in, sel/gnt/valid/busy out)
module mux16_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux16_rr_sched_if.slave   bus
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, idx;
  logic [N_CH-1:0]  gnt_q, gnt_d, r;
  logic [7:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d, any, hold;
  assign r = bus.req & bus.mask;
  rr_pick u_pick (.r(r), .ptr(ptr_q), .idx(idx), .any(any));
  // hold: current owner still enabled and requesting; a cleared mask bit looks like a release
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hold    = bus.en && r[sel_q];
    if (state_q == SETTLE) begin
      state_d = hold ? GRANT : IDLE;
      gnt_d   = hold ? gnt_q : '0;
      cnt_d   = '0;
    end else if (state_q == GRANT && hold && cnt_q != HOLD_LAST) begin
      cnt_d = cnt_q + 8'd1;
    end else if (bus.en && any) begin
      state_d = SETTLE;
      sel_d   = idx;
      gnt_d   = N_CH'(1) << idx;
      ptr_d   = idx;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
    end
    valid_d = state_d == GRANT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '1;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;
  assign bus.busy  = state_q != IDLE;
endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: directed scenarios plus random traffic against a behavioural scheduler model
module tb_mux16_rr_sched;
  localparam int MAX_HOLD = 8;
  localparam int P_IDLE = 0, P_SETTLE = 1, P_GRANT = 2;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, failures = 0;
  int m_phase, m_sel, m_ptr, m_run;
  int grants[$];
  logic prev_valid;
  int saved_sel;
  mux16_rr_sched_if bus();
  mux16_rr_sched #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 1; k <= 16; k++)
      if (r[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_sel = 0; m_ptr = 15; m_run = 0; prev_valid = 1'b0;
  endtask

  // m_run counts valid cycles already shown for the current grant
  task automatic model_edge();
    logic [15:0] r;
    bit owner_on;
    int p;
    r = bus.req & bus.mask;
    owner_on = bus.en && r[m_sel];
    p = pick(r, m_ptr);
    if (m_phase == P_SETTLE) begin
      m_phase = owner_on ? P_GRANT : P_IDLE;
      m_run = 1;
    end else if (m_phase == P_GRANT && owner_on && m_run < MAX_HOLD) begin
      m_run++;
    end else if (bus.en && p >= 0) begin
      m_phase = P_SETTLE; m_sel = p; m_ptr = p;
    end else begin
      m_phase = P_IDLE;
    end
  endtask

  task automatic compare();
    chk("sel", 32'(bus.sel), 32'(m_sel));
    chk("gnt", 32'(bus.gnt), m_phase == P_IDLE ? 32'd0 : 32'd1 << m_sel);
    chk("valid", 32'(bus.valid), 32'(m_phase == P_GRANT));
    chk("busy", 32'(bus.busy), 32'(m_phase != P_IDLE));
    if (bus.valid && !prev_valid) grants.push_back(int'(bus.sel));
    prev_valid = bus.valid;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    grants.delete();
  endtask

  task automatic wait_valid(input int ch, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      found = bus.valid && (ch < 0 || int'(bus.sel) == ch);
    end
    chk("wait_valid", 32'(found), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; bus.en = 1'b0; bus.req = '0; bus.mask = 16'hFFFF;
    #2;
    do_reset();
    // single request: 1-cycle select, 2-cycle valid, 8-cycle hold, one gap, re-grant
    bus.req = 16'h0010; bus.en = 1'b1;
    step();
    chk("single_sel", 32'(bus.sel), 32'd4);
    chk("single_gnt", 32'(bus.gnt), 32'h0010);
    chk("single_settle_valid", 32'(bus.valid), 32'd0);
    step();
    chk("single_valid", 32'(bus.valid), 32'd1);
    repeat (7) step();
    chk("single_valid8", 32'(bus.valid), 32'd1);
    step();
    chk("single_gap", 32'(bus.valid), 32'd0);
    chk("single_regnt", 32'(bus.gnt), 32'h0010);
    step();
    chk("single_revalid", 32'(bus.valid), 32'd1);
    // round-robin wrap between channels 0 and 15
    do_reset();
    bus.req = 16'h8001; bus.en = 1'b1;
    repeat (45) step();
    chk("wrap_count", 32'(grants.size() >= 4), 32'd1);
    chk("wrap_g0", 32'(grants[0]), 32'd0);
    chk("wrap_g1", 32'(grants[1]), 32'd15);
    chk("wrap_g2", 32'(grants[2]), 32'd0);
    chk("wrap_g3", 32'(grants[3]), 32'd15);
    // early release of channel 3 hands over to pending channel 9
    do_reset();
    bus.req = 16'h0208; bus.en = 1'b1;
    step();
    chk("rel_sel3", 32'(bus.sel), 32'd3);
    step(); step();
    chk("rel_valid2", 32'(bus.valid), 32'd1);
    bus.req = 16'h0200;
    step();
    chk("rel_gap", 32'(bus.valid), 32'd0);
    chk("rel_sel9", 32'(bus.sel), 32'd9);
    chk("rel_gnt9", 32'(bus.gnt), 32'h0200);
    step();
    chk("rel_valid9", 32'(bus.valid), 32'd1);
    // masking: only channels 0 and 6, alternating; mask drop releases channel 6
    do_reset();
    bus.req = 16'hFFFF; bus.mask = 16'h0041; bus.en = 1'b1;
    repeat (40) step();
    chk("mask_count", 32'(grants.size() >= 4), 32'd1);
    foreach (grants[i]) chk("mask_alt", 32'(grants[i]), (i % 2) ? 32'd6 : 32'd0);
    wait_valid(6, 20);
    bus.mask = 16'h0001;
    step();
    chk("mask_rel_valid", 32'(bus.valid), 32'd0);
    chk("mask_rel_sel", 32'(bus.sel), 32'd0);
    chk("mask_rel_gnt", 32'(bus.gnt), 32'h0001);
    // disable during grant
    bus.mask = 16'hFFFF;
    wait_valid(-1, 20);
    saved_sel = int'(bus.sel);
    bus.en = 1'b0;
    step();
    chk("dis_gnt", 32'(bus.gnt), 32'd0);
    chk("dis_valid", 32'(bus.valid), 32'd0);
    chk("dis_sel", 32'(bus.sel), 32'(saved_sel));
    chk("dis_busy", 32'(bus.busy), 32'd0);
    step();
    chk("dis_hold_idle", 32'(bus.busy), 32'd0);
    // async reset mid-grant, then scheduling restarts at channel 0
    bus.en = 1'b1; bus.req = 16'h0420;
    wait_valid(-1, 20);
    do_reset();
    bus.req = 16'hFFFF;
    step();
    chk("rst_sel0", 32'(bus.sel), 32'd0);
    chk("rst_gnt0", 32'(bus.gnt), 32'h0001);
    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.req = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 11) == 0) bus.mask = 16'($urandom) | 16'($urandom);
      bus.en = $urandom_range(0, 19) != 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
